// File: rtl/alu_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_iter : multi-cycle ALU, nibble-serial binary/BCD add-sub, bit-serial   |
// |            shifts/rotates and shift-and-add unsigned multiply.             |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module alu_iter #(
    parameter int W  = 16,
    parameter int CW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          start,
    input  logic [3:0]    op,
    input  logic [1:0]    wsel,
    input  logic [W-1:0]  l,
    input  logic [W-1:0]  r,
    input  logic [CW-1:0] cnt,
    input  logic          ci,
    input  logic          vi,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  res,
    output logic [W-1:0]  resh,
    output logic          co,
    output logic          vo,
    output logic          so,
    output logic          zo
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIN = 2'd2} state_t;
    localparam logic [5:0] c_w = 6'(W);

    function automatic logic [W-1:0] f_mask(input logic [5:0] aw);
        logic [W-1:0] m;
        for (int i = 0; i < W; i++) m[i] = (i < int'(aw));
        return m;
    endfunction

    function automatic logic [W-1:0] f_msb(input logic [5:0] aw);
        logic [W-1:0] m;
        for (int i = 0; i < W; i++) m[i] = (i == int'(aw) - 1);
        return m;
    endfunction

    state_t           r_state;
    logic [3:0]       r_op;
    logic [5:0]       r_aw, r_cnt;
    logic [2:0]       r_idx;
    logic [2*W-1:0]   r_x, r_acc;
    logic [W-1:0]     r_y;
    logic             r_c, r_v;

    logic [5:0]       w_aw_in, w_n_in;
    logic [W-1:0]     w_mask_in, w_mask, w_msb, w_xl;
    logic [3:0]       w_ln, w_rn, w_rn_b, w_nib;
    logic [4:0]       w_bin, w_bcd_s, w_bcd_d;
    logic             w_vstep, w_top;
    logic [2*W-1:0]   w_x_nx, w_acc_nx;
    logic [W-1:0]     w_y_nx;
    logic             w_c_nx, w_v_nx;

    logic [3:0]       w_f_op;
    logic [5:0]       w_f_aw;
    logic [W-1:0]     w_f_x, w_f_mask, w_f_msb, w_f_res, w_f_hi;
    logic [2*W-1:0]   w_f_acc;
    logic             w_f_c, w_f_v, w_f_co, w_f_so, w_f_zo, w_fin_go;

    always_comb begin
        case (wsel)
            2'd0:    w_aw_in = 6'd8;
            2'd1:    w_aw_in = 6'd16;
            default: w_aw_in = 6'd32;
        endcase
        if (w_aw_in > c_w) w_aw_in = c_w;
        w_mask_in = f_mask(w_aw_in);
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3: w_n_in = w_aw_in >> 2;
            4'd4, 4'd5, 4'd6, 4'd7: w_n_in = 6'(cnt);
            4'd8:                   w_n_in = w_aw_in;
            default:                w_n_in = 6'd0;
        endcase
    end

    // One RUN step: next value of every working register
    always_comb begin
        w_mask   = f_mask(r_aw);
        w_msb    = f_msb(r_aw);
        w_ln     = r_x[3:0];
        w_rn     = r_y[3:0];
        w_rn_b   = r_op[0] ? ~w_rn : w_rn;
        w_bin    = {1'b0, w_ln} + {1'b0, w_rn_b} + {4'd0, r_c};
        w_bcd_s  = {1'b0, w_ln} + {1'b0, w_rn} + {4'd0, r_c};
        w_bcd_d  = {1'b0, w_ln} - {1'b0, w_rn} - {4'd0, ~r_c};
        w_vstep  = (w_ln[3] == w_rn_b[3]) && (w_bin[3] != w_ln[3]);
        w_xl     = r_x[W-1:0];
        w_top    = |(w_xl & w_msb);
        w_x_nx   = r_x;
        w_y_nx   = r_y;
        w_acc_nx = r_acc;
        w_c_nx   = r_c;
        w_v_nx   = r_v;
        w_nib    = 4'd0;
        case (r_op)
            4'd0, 4'd1: begin
                w_nib  = w_bin[3:0];
                w_c_nx = w_bin[4];
                w_v_nx = w_vstep;
            end
            4'd2: begin
                w_v_nx = w_vstep;
                if (w_bcd_s > 5'd9) begin
                    w_nib  = w_bcd_s[3:0] + 4'd6;
                    w_c_nx = 1'b1;
                end else begin
                    w_nib  = w_bcd_s[3:0];
                    w_c_nx = 1'b0;
                end
            end
            4'd3: begin
                w_v_nx = w_vstep;
                if (w_bcd_d[4]) begin
                    w_nib  = w_bcd_d[3:0] + 4'd10;
                    w_c_nx = 1'b0;
                end else begin
                    w_nib  = w_bcd_d[3:0];
                    w_c_nx = 1'b1;
                end
            end
            4'd4: begin
                w_c_nx = w_top;
                w_x_nx = {{W{1'b0}}, (w_xl << 1) & w_mask};
            end
            4'd5: begin
                w_c_nx = w_top;
                w_x_nx = {{W{1'b0}}, ((w_xl << 1) | {{(W-1){1'b0}}, r_c}) & w_mask};
            end
            4'd6: begin
                w_c_nx = w_xl[0];
                w_x_nx = {{W{1'b0}}, w_xl >> 1};
            end
            4'd7: begin
                w_c_nx = w_xl[0];
                w_x_nx = {{W{1'b0}}, (w_xl >> 1) | (r_c ? w_msb : {W{1'b0}})};
            end
            4'd8: begin
                w_acc_nx = r_y[0] ? r_acc + r_x : r_acc;
                w_x_nx   = r_x << 1;
                w_y_nx   = r_y >> 1;
            end
            default: ;
        endcase
        if (r_op <= 4'd3) begin
            w_acc_nx = r_acc | ({{(2*W-4){1'b0}}, w_nib} << {r_idx, 2'b00});
            w_x_nx   = r_x >> 4;
            w_y_nx   = r_y >> 4;
        end
    end

    // Result/flag formation; zero-step ops take their sources straight from the inputs
    always_comb begin
        if (r_state == S_IDLE) begin
            w_f_op  = op;
            w_f_aw  = w_aw_in;
            w_f_x   = l & w_mask_in;
            w_f_acc = '0;
            w_f_c   = ci;
            w_f_v   = vi;
        end else begin
            w_f_op  = r_op;
            w_f_aw  = r_aw;
            w_f_x   = w_x_nx[W-1:0];
            w_f_acc = w_acc_nx;
            w_f_c   = w_c_nx;
            w_f_v   = w_v_nx;
        end
        w_f_mask = f_mask(w_f_aw);
        w_f_msb  = f_msb(w_f_aw);
        w_f_hi   = '0;
        case (w_f_op)
            4'd0, 4'd1, 4'd2, 4'd3: w_f_res = w_f_acc[W-1:0] & w_f_mask;
            4'd4, 4'd5, 4'd6, 4'd7: w_f_res = w_f_x & w_f_mask;
            4'd8: begin
                w_f_res = w_f_acc[W-1:0] & w_f_mask;
                w_f_hi  = W'(w_f_acc >> w_f_aw) & w_f_mask;
            end
            default:                w_f_res = '0;
        endcase
        w_f_co   = (w_f_op == 4'd8) ? |w_f_hi : w_f_c;
        w_f_so   = (w_f_op == 4'd8) ? |(w_f_hi & w_f_msb) : |(w_f_res & w_f_msb);
        w_f_zo   = ~|(w_f_res | w_f_hi);
        w_fin_go = ((r_state == S_IDLE) && start && (w_n_in == 6'd0)) ||
                   ((r_state == S_RUN) && (r_cnt == 6'd0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            res     <= '0;
            resh    <= '0;
            co      <= 1'b0;
            vo      <= 1'b0;
            so      <= 1'b0;
            zo      <= 1'b0;
            r_op    <= '0;
            r_aw    <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_acc   <= '0;
            r_c     <= 1'b0;
            r_v     <= 1'b0;
        end else if (en) begin
            if (w_fin_go) begin
                res  <= w_f_res;
                resh <= w_f_hi;
                co   <= w_f_co;
                vo   <= w_f_v;
                so   <= w_f_so;
                zo   <= w_f_zo;
            end
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_op  <= op;
                        r_aw  <= w_aw_in;
                        r_cnt <= w_n_in - 6'd1;
                        r_idx <= '0;
                        r_x   <= {{W{1'b0}}, l & w_mask_in};
                        r_y   <= r & w_mask_in;
                        r_acc <= '0;
                        r_c   <= ci;
                        r_v   <= vi;
                        busy  <= 1'b1;
                        if (w_n_in == 6'd0) begin
                            r_state <= S_FIN;
                            done    <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_x   <= w_x_nx;
                    r_y   <= w_y_nx;
                    r_acc <= w_acc_nx;
                    r_c   <= w_c_nx;
                    r_v   <= w_v_nx;
                    r_cnt <= r_cnt - 6'd1;
                    r_idx <= r_idx + 3'd1;
                    if (r_cnt == 6'd0) begin
                        r_state <= S_FIN;
                        done    <= 1'b1;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_iter : self-checking bench for alu_iter (W=16).                     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_alu_iter;
    localparam int W  = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, en, start, ci, vi;
    logic [3:0]    op;
    logic [1:0]    wsel;
    logic [W-1:0]  l, r;
    logic [CW-1:0] cnt;
    logic          busy, done, co, vo, so, zo;
    logic [W-1:0]  res, resh;

    int n_vec = 0;
    int n_err = 0;

    alu_iter #(.W(W), .CW(CW)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .op(op), .wsel(wsel),
        .l(l), .r(r), .cnt(cnt), .ci(ci), .vi(vi), .busy(busy), .done(done),
        .res(res), .resh(resh), .co(co), .vo(vo), .so(so), .zo(zo)
    );

    always #5 clk = ~clk;

    // Reference: whole-word arithmetic for binary/MUL/shifts, decimal digit rules for BCD
    function automatic void model(input logic [3:0] o, input logic [1:0] ws,
                                  input logic [W-1:0] la, input logic [W-1:0] rb,
                                  input int c, input logic cin, input logic vin,
                                  output logic [W-1:0] xres, output logic [W-1:0] xresh,
                                  output logic [3:0] xfl, output int xn);
        int aw, nd, k, da, db, dbx, t;
        logic [63:0] mask, a, b, s, p, hi, ring, rmask;
        logic cy, v, sv, zv;
        aw = (ws == 2'd0) ? 8 : (ws == 2'd1) ? 16 : 32;
        if (aw > W) aw = W;
        mask = (64'd1 << aw) - 64'd1;
        a = 64'(la) & mask;
        b = 64'(rb) & mask;
        p = 0; hi = 0; cy = cin; v = vin; xn = 0;
        case (o)
            4'd0, 4'd1: begin
                if (o == 4'd1) b = ~b & mask;
                s  = a + b + 64'(cin);
                p  = s & mask;
                cy = s[aw];
                v  = (a[aw-1] == b[aw-1]) && (p[aw-1] != a[aw-1]);
                xn = aw / 4;
            end
            4'd2, 4'd3: begin
                nd = aw / 4;
                for (int i = 0; i < nd; i++) begin
                    da  = int'((a >> (4 * i)) & 64'd15);
                    db  = int'((b >> (4 * i)) & 64'd15);
                    dbx = (o == 4'd3) ? 15 - db : db;
                    if (i == nd - 1) begin
                        t = da + dbx + int'(cy);
                        v = (((da >> 3) & 1) == ((dbx >> 3) & 1)) && (((t >> 3) & 1) != ((da >> 3) & 1));
                    end
                    if (o == 4'd2) begin
                        t = da + db + int'(cy);
                        if (t > 9) begin t = t + 6; cy = 1'b1; end else cy = 1'b0;
                    end else begin
                        t = da - db - (1 - int'(cy));
                        if (t < 0) begin t = t + 10; cy = 1'b0; end else cy = 1'b1;
                    end
                    p = p | (64'(t & 15) << (4 * i));
                end
                xn = nd;
            end
            4'd4: begin
                p  = (a << c) & mask;
                cy = (c == 0) ? cin : (c > aw) ? 1'b0 : a[aw-c];
                xn = c;
            end
            4'd6: begin
                p  = a >> c;
                cy = (c == 0) ? cin : (c > aw) ? 1'b0 : a[c-1];
                xn = c;
            end
            4'd5, 4'd7: begin
                k     = c % (aw + 1);
                rmask = (64'd1 << (aw + 1)) - 64'd1;
                ring  = (64'(cin) << aw) | a;
                if (o == 4'd5) ring = ((ring << k) | (ring >> (aw + 1 - k))) & rmask;
                else           ring = ((ring >> k) | (ring << (aw + 1 - k))) & rmask;
                cy = ring[aw];
                p  = ring & mask;
                xn = c;
            end
            4'd8: begin
                s  = a * b;
                p  = s & mask;
                hi = (s >> aw) & mask;
                cy = (hi != 0);
                xn = aw;
            end
            default: begin
                p  = 0;
                cy = cin;
            end
        endcase
        sv    = (o == 4'd8) ? hi[aw-1] : p[aw-1];
        zv    = ((p | hi) == 0);
        xres  = W'(p);
        xresh = W'(hi);
        xfl   = {cy, v, sv, zv};
    endfunction

    task automatic run_op(input logic [3:0] o, input logic [1:0] ws, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [CW-1:0] c, input logic cin,
                          input logic vin, output int edges, output logic [W-1:0] ores,
                          output logic [W-1:0] oresh, output logic [3:0] ofl, output logic otail);
        @(negedge clk);
        op = o; wsel = ws; l = a; r = b; cnt = c; ci = cin; vi = vin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        l = W'($urandom); r = W'($urandom); op = 4'($urandom); wsel = 2'($urandom);
        cnt = CW'($urandom); ci = ~cin; vi = ~vin;
        edges = 1;
        while (done !== 1'b1 && edges < 200) begin
            @(negedge clk);
            edges++;
        end
        ores  = res;
        oresh = resh;
        ofl   = {co, vo, so, zo};
        @(negedge clk);
        otail = busy | done;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; start = 1'b0; op = '0; wsel = '0; l = '0; r = '0;
        cnt = '0; ci = 1'b0; vi = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({busy, done} !== 2'b00) begin
            n_err++; $display("FAIL reset busy/done: got %b expected 00", {busy, done});
        end
        n_vec++;
        if (res !== '0 || resh !== '0) begin
            n_err++; $display("FAIL reset res/resh: got %h/%h expected 0/0", res, resh);
        end
        n_vec++;
        if ({co, vo, so, zo} !== 4'b0000) begin
            n_err++; $display("FAIL reset flags: got %b expected 0000", {co, vo, so, zo});
        end
        rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0] op; logic [1:0] ws; logic [W-1:0] l, r; logic [CW-1:0] c;
        logic ci, vi; logic [W-1:0] eres, eresh; logic [3:0] efl; int eedges;
    } vec_t;

    task automatic test_directed;
        vec_t tbl[8];
        int edges; logic [W-1:0] ores, oresh; logic [3:0] ofl; logic otail;
        // flags packed as {co, vo, so, zo}
        tbl[0] = '{4'd2, 2'd0, 16'hAB99, 16'h0001, 4'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'b1001, 3};
        tbl[1] = '{4'd1, 2'd1, 16'h8000, 16'h0001, 4'd0, 1'b1, 1'b0, 16'h7FFF, 16'h0000, 4'b1100, 5};
        tbl[2] = '{4'd3, 2'd1, 16'h1000, 16'h0001, 4'd0, 1'b1, 1'b0, 16'h0999, 16'h0000, 4'b1000, 5};
        tbl[3] = '{4'd3, 2'd1, 16'h0000, 16'h0001, 4'd0, 1'b1, 1'b0, 16'h9999, 16'h0000, 4'b0010, 5};
        tbl[4] = '{4'd5, 2'd0, 16'h0081, 16'h0000, 4'd3, 1'b1, 1'b0, 16'h000E, 16'h0000, 4'b0000, 4};
        tbl[5] = '{4'd4, 2'd0, 16'h1240, 16'h0000, 4'd0, 1'b1, 1'b0, 16'h0040, 16'h0000, 4'b1000, 1};
        tbl[6] = '{4'd8, 2'd1, 16'hFFFF, 16'hFFFF, 4'd0, 1'b0, 1'b0, 16'h0001, 16'hFFFE, 4'b1010, 17};
        tbl[7] = '{4'd9, 2'd1, 16'h1234, 16'h5678, 4'd5, 1'b1, 1'b1, 16'h0000, 16'h0000, 4'b1101, 1};
        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].op, tbl[i].ws, tbl[i].l, tbl[i].r, tbl[i].c, tbl[i].ci, tbl[i].vi,
                   edges, ores, oresh, ofl, otail);
            n_vec++;
            if (edges !== tbl[i].eedges) begin
                n_err++; $display("FAIL directed[%0d] latency: got %0d expected %0d", i, edges, tbl[i].eedges);
            end
            n_vec++;
            if (ores !== tbl[i].eres) begin
                n_err++; $display("FAIL directed[%0d] res: got %h expected %h", i, ores, tbl[i].eres);
            end
            n_vec++;
            if (oresh !== tbl[i].eresh) begin
                n_err++; $display("FAIL directed[%0d] resh: got %h expected %h", i, oresh, tbl[i].eresh);
            end
            n_vec++;
            if (ofl !== tbl[i].efl) begin
                n_err++; $display("FAIL directed[%0d] flags: got %b expected %b", i, ofl, tbl[i].efl);
            end
            n_vec++;
            if (otail !== 1'b0) begin
                n_err++; $display("FAIL directed[%0d] idle after done: got %b expected 0", i, otail);
            end
        end
    endtask

    task automatic test_random;
        int edges, xn; logic [W-1:0] ores, oresh, xres, xresh; logic [3:0] ofl, xfl; logic otail;
        logic [3:0] o; logic [1:0] ws; logic [W-1:0] a, b; logic [CW-1:0] c; logic cin, vin;
        for (int i = 0; i < 60; i++) begin
            o = 4'($urandom_range(0, 10)); ws = 2'($urandom); a = W'($urandom); b = W'($urandom);
            c = CW'($urandom); cin = 1'($urandom); vin = 1'($urandom);
            model(o, ws, a, b, int'(c), cin, vin, xres, xresh, xfl, xn);
            run_op(o, ws, a, b, c, cin, vin, edges, ores, oresh, ofl, otail);
            n_vec++;
            if (edges !== xn + 1) begin
                n_err++; $display("FAIL random[%0d] op%0d latency: got %0d expected %0d", i, o, edges, xn + 1);
            end
            n_vec++;
            if (ores !== xres || oresh !== xresh) begin
                n_err++; $display("FAIL random[%0d] op%0d ws%0d %h,%h res: got %h:%h expected %h:%h",
                                  i, o, ws, a, b, oresh, ores, xresh, xres);
            end
            n_vec++;
            if (ofl !== xfl) begin
                n_err++; $display("FAIL random[%0d] op%0d ws%0d %h,%h flags: got %b expected %b",
                                  i, o, ws, a, b, ofl, xfl);
            end
            n_vec++;
            if (otail !== 1'b0) begin
                n_err++; $display("FAIL random[%0d] idle after done: got %b expected 0", i, otail);
            end
        end
    endtask

    task automatic test_back_to_back;
        int dk[4]; int ndone;
        ndone = 0;
        for (int i = 0; i < 4; i++) dk[i] = 0;
        @(negedge clk);
        op = 4'd0; wsel = 2'd0; l = 16'h0012; r = 16'h0034; ci = 1'b0; vi = 1'b0; start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (ndone < 4) dk[ndone] = k;
                ndone++;
            end
        end
        start = 1'b0;
        n_vec++;
        if (ndone !== 3 || dk[0] !== 3 || dk[1] !== 7 || dk[2] !== 11) begin
            n_err++; $display("FAIL back_to_back done cycles: got %0d pulses at %0d,%0d,%0d expected 3 at 3,7,11",
                              ndone, dk[0], dk[1], dk[2]);
        end
        n_vec++;
        if (res !== 16'h0046) begin
            n_err++; $display("FAIL back_to_back res: got %h expected 0046", res);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_ignore;
        logic [W-1:0] xres, xresh, gres; logic [3:0] xfl; int xn, ndone, first; logic tail;
        model(4'd1, 2'd1, 16'h1234, 16'h0235, 4, 1'b1, 1'b0, xres, xresh, xfl, xn);
        ndone = 0; first = 0; tail = 1'b0; gres = '0;
        @(negedge clk);
        op = 4'd1; wsel = 2'd1; l = 16'h1234; r = 16'h0235; ci = 1'b1; vi = 1'b0; start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                if (first == 0) begin first = k; gres = res; end
            end
            if (k >= 6) tail = tail | busy;
            if (k == 2 || k == 5) begin
                start = 1'b1; op = 4'd8; l = 16'hFFFF; r = 16'h00FF; wsel = 2'd0;
            end else begin
                start = 1'b0;
            end
        end
        n_vec++;
        if (ndone !== 1 || first !== 5) begin
            n_err++; $display("FAIL ignore done: got %0d pulses first at %0d expected 1 at 5", ndone, first);
        end
        n_vec++;
        if (gres !== xres) begin
            n_err++; $display("FAIL ignore res: got %h expected %h", gres, xres);
        end
        n_vec++;
        if (tail !== 1'b0) begin
            n_err++; $display("FAIL ignore busy after done: got %b expected 0", tail);
        end
    endtask

    task automatic test_stall;
        logic [W-1:0] a, b, xres, xresh, gres; logic [3:0] xfl; int xn, first; logic held, tail;
        a = W'($urandom_range(1, 255)); b = W'($urandom_range(1, 255));
        model(4'd8, 2'd0, a, b, 0, 1'b0, 1'b0, xres, xresh, xfl, xn);
        first = 0; held = 1'b1; tail = 1'b1; gres = '0;
        @(negedge clk);
        op = 4'd8; wsel = 2'd0; l = a; r = b; ci = 1'b0; vi = 1'b0; start = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1 && first == 0) begin first = k; gres = res; end
            if (k == 12 || k == 13) held = held & (done === 1'b1);
            if (k == 14) tail = busy | done;
            en = !(k == 3 || k == 4 || k == 11 || k == 12);
        end
        en = 1'b1;
        n_vec++;
        if (first !== xn + 3) begin
            n_err++; $display("FAIL stall latency: got %0d expected %0d", first, xn + 3);
        end
        n_vec++;
        if (gres !== xres) begin
            n_err++; $display("FAIL stall res: got %h expected %h", gres, xres);
        end
        n_vec++;
        if (held !== 1'b1 || tail !== 1'b0) begin
            n_err++; $display("FAIL stall done hold: got held=%b tail=%b expected held=1 tail=0", held, tail);
        end
    endtask

    task automatic test_reset_mid;
        int edges; logic [W-1:0] ores, oresh; logic [3:0] ofl; logic otail, seen;
        run_op(4'd0, 2'd0, 16'h0001, 16'h0001, 4'd0, 1'b0, 1'b0, edges, ores, oresh, ofl, otail);
        n_vec++;
        if (ores !== 16'h0002) begin
            n_err++; $display("FAIL reset_mid setup res: got %h expected 0002", ores);
        end
        seen = 1'b0;
        @(negedge clk);
        op = 4'd8; wsel = 2'd1; l = 16'hFFFF; r = 16'hFFFF; ci = 1'b0; vi = 1'b0; start = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 5) begin
                n_vec++;
                if ({busy, done} !== 2'b00 || res !== '0 || resh !== '0 || {co, vo, so, zo} !== 4'b0000) begin
                    n_err++; $display("FAIL reset_mid state: got busy=%b done=%b res=%h resh=%h expected all 0",
                                      busy, done, res, resh);
                end
            end
            if (k > 5) seen = seen | (done === 1'b1) | (busy === 1'b1);
            rst = (k == 4);
        end
        rst = 1'b0;
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++; $display("FAIL reset_mid resumed: got activity=%b expected 0", seen);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_back_to_back;
        test_ignore;
        test_stall;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_iter.md
# alu_iter

Multi-cycle, width-parametrised successor to the 65C816 datapath ALU. It latches operands on a start handshake and computes binary or BCD add/subtract nibble-serially. It also performs multi-bit shifts and rotates one bit per cycle, and unsigned multiply by shift-and-add. Intended as the shared arithmetic engine for wide and extended-op instructions next to the CPU core. It is clocked by the core clock and gated by the core clock-enable.

## Interface
- W, 16, datapath width; legal values 8, 16, 32.
- CW, $clog2(W), width of the shift-count port.
- CLK  in  1  core clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  clock enable; when 0, all state, outputs and counters hold.
- START  in  1  request; accepted only when EN=1 and BUSY=0.
- OP  in  4  operation code:
  - 0 ADD, 1 SUB, 2 ADD-BCD, 3 SUB-BCD.
  - 4 ASL, 5 ROL, 6 LSR, 7 ROR.
  - 8 MUL.
  - 9–15 reserved.
- WSEL  in  2  active width: 0=8, 1=16, 2/3=32. Clamped to W.
- L, R  in  W  operands; bits above the active width are ignored.
- CNT  in  CW  shift count (OP 4–7).
- CI, VI  in  1  carry-in, overflow-in.
- BUSY  out  1  high while state≠IDLE.
- DONE  out  1  one-cycle pulse; RES and flags are valid from this cycle.
- RES  out  W  result (MUL: low half); zero above the active width.
- RESH  out  W  MUL high half; 0 for other ops.
- CO, VO, SO, ZO  out  1  carry, overflow, sign, zero.

## Operation
- States:
  - IDLE: on an accepted START, go to RUN if N>0, else go to FIN.
  - RUN: one step per EN cycle. Step counter loads N−1 on accept. On the step with counter=0, go to FIN.
  - FIN: DONE=1, then go to IDLE unconditionally.
- On accept, latch OP, WSEL (clamped), CI, VI, CNT, and L/R masked to the active width AW. Later input changes have no effect.
- START while BUSY, including in FIN, is ignored; there is no queueing.
- N: AW/4 for OP 0–3; CNT for OP 4–7; AW for OP 8; 0 for reserved ops.
- ADD: one nibble per step, LSB first, computing l+r+c. The carry chain starts at CI.
- SUB: l+~r+c per nibble. CI=1 means no borrow; CO=1 means no borrow.
- ADD-BCD: per nibble s=l+r+c; if s>9 then s=s+6 and c=1, else c=0.
- SUB-BCD: per nibble d=l−r−(1−c); if d<0 then d=d+10 and c=0, else c=1.
- Binary add/sub VO is signed overflow at bit AW−1. BCD VO is signed overflow of the top nibble's binary sum before decimal adjust.
- ASL/LSR fill with 0. ROL/ROR rotate through the carry, an AW+1-bit ring whose initial carry is CI. CO is the last bit shifted out. CNT=0 gives RES=L and CO=CI. Shifts operate on L; VO=VI.
- MUL: unsigned AW×AW → 2·AW, one multiplier bit per step.
  - RES holds the low AW bits, RESH the high AW bits.
  - CO=1 iff RESH≠0; SO=RESH[AW−1]; ZO=1 iff the full product is 0; VO=VI.
- Reserved ops: RES=0, RESH=0, CO=CI, VO=VI, SO=0, ZO=1.
- Flags for all other ops: SO=RES[AW−1]; ZO=1 iff RES[AW−1:0]=0.
- RES, RESH and flags are registered on entry to FIN. They hold until the next FIN and do not change during RUN.

## Timing
- Reset: state=IDLE; BUSY=0, DONE=0, RES=0, RESH=0, CO=VO=SO=ZO=0.
- RST has priority over EN and START. Reset mid-RUN aborts the operation; no DONE pulse is produced.
- Latency with EN held high, START accepted at edge 0:
  - BUSY=1 from edge 1.
  - DONE=1 in the cycle after edge N+1.
  - BUSY=0 after edge N+2.
- A new START is accepted on the first cycle with BUSY=0, giving a back-to-back throughput of one op per N+2 cycles.
- EN=0 cycles stretch latency one-for-one. While EN=0, the DONE pulse is held and not repeated.
- Outputs are purely registered; there is no combinational path from inputs to outputs.

## Test plan
- W=16, WSEL=0, ADD-BCD, L=0x0099, R=0x0001, CI=0 → RES=0x0000, CO=1, ZO=1, SO=0. DONE after edge 3.
- WSEL=1, SUB, L=0x8000, R=0x0001, CI=1 → RES=0x7FFF, CO=1, VO=1, SO=0. DONE after edge 5.
- WSEL=1, SUB-BCD, CI=1:
  - L=0x1000, R=0x0001 → RES=0x0999, CO=1.
  - L=0x0000, R=0x0001 → RES=0x9999, CO=0, SO=1.
- WSEL=0, ROL, CNT=3, L=0x81, CI=1 → RES=0x0E, CO=0. DONE after edge 4.
- WSEL=0, ASL, CNT=0, L=0x40, CI=1 → RES=0x40, CO=1. DONE after edge 1.
- W=16, WSEL=1, MUL, L=R=0xFFFF → RES=0x0001, RESH=0xFFFE, CO=1, SO=1, ZO=0. DONE after edge 17.
- Abort and stall:
  - START pulsed during RUN → ignored.
  - EN low for 2 cycles mid-RUN → DONE delayed by exactly 2.
  - RST mid-RUN → BUSY=0 and RES=0 next cycle, no DONE pulse.
